// File: rtl/krake_port_arb.sv
// Round-robin arbiter that shares one krake_port register bus between NUM_M requesters.
// Optional macro ARB_TIMEOUT_EN adds an ack watchdog that aborts a stalled transaction.
module krake_port_arb #(
    parameter int NUM_M   = 4,
    parameter int TIMEOUT = 16
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [NUM_M-1:0]   m_req_i,
    input  logic [NUM_M-1:0]   m_we_i,
    input  logic [5*NUM_M-1:0] m_adr_i,
    input  logic [8*NUM_M-1:0] m_dat_i,
    output logic [NUM_M-1:0]   m_ack_o,
    output logic [7:0]         m_dat_o,
    output logic               m_err_o,
    output logic [NUM_M-1:0]   gnt_o,
    output logic               stb_o,
    output logic               we_o,
    output logic [4:0]         adr_o,
    output logic [7:0]         dat_o,
    input  logic               ack_i,
    input  logic [7:0]         dat_i,
    output logic [1:0]         dbg_state_o
);

    localparam int PW = (NUM_M > 1) ? $clog2(NUM_M) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       state;
    logic [PW-1:0]    ptr;
    logic [PW-1:0]    gidx;
    logic [PW-1:0]    next_ptr;

    logic             sel_valid;
    logic [PW-1:0]    sel_idx;
    logic [NUM_M-1:0] sel_onehot;
    logic             sel_we;
    logic [4:0]       sel_adr;
    logic [7:0]       sel_dat;

    // Scan offsets from high to low so the requester closest to the pointer wins.
    always_comb begin
        int j;
        logic [PW-1:0] jj;
        sel_valid = 1'b0;
        sel_idx   = '0;
        j         = 0;
        jj        = '0;
        for (int i = NUM_M - 1; i >= 0; i--) begin
            j = int'(ptr) + i;
            if (j >= NUM_M) j = j - NUM_M;
            jj = PW'(j);
            if (m_req_i[jj]) begin
                sel_valid = 1'b1;
                sel_idx   = jj;
            end
        end
    end

    always_comb begin
        sel_we     = 1'b0;
        sel_adr    = '0;
        sel_dat    = '0;
        sel_onehot = '0;
        for (int n = 0; n < NUM_M; n++) begin
            if (PW'(n) == sel_idx) begin
                sel_we        = m_we_i[n];
                sel_adr       = m_adr_i[5*n +: 5];
                sel_dat       = m_dat_i[8*n +: 8];
                sel_onehot[n] = 1'b1;
            end
        end
    end

    assign next_ptr    = (gidx == PW'(NUM_M - 1)) ? '0 : gidx + PW'(1);
    assign dbg_state_o = state;

`ifdef ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0] cnt;
    logic          err_q;

    assign m_err_o = err_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state   <= S_IDLE;
            ptr     <= '0;
            gidx    <= '0;
            cnt     <= '0;
            err_q   <= 1'b0;
            m_ack_o <= '0;
            m_dat_o <= '0;
            gnt_o   <= '0;
            stb_o   <= 1'b0;
            we_o    <= 1'b0;
            adr_o   <= '0;
            dat_o   <= '0;
        end else begin
            stb_o   <= 1'b0;
            m_ack_o <= '0;
            case (state)
                S_IDLE: begin
                    if (sel_valid) begin
                        we_o  <= sel_we;
                        adr_o <= sel_adr;
                        dat_o <= sel_dat;
                        gnt_o <= sel_onehot;
                        gidx  <= sel_idx;
                        stb_o <= 1'b1;
                        cnt   <= '0;
                        state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    // A real ack beats the watchdog when both land on the same edge.
                    if (!stb_o && ack_i) begin
                        m_dat_o <= dat_i;
                        m_ack_o <= gnt_o;
                        err_q   <= 1'b0;
                        state   <= S_DONE;
                    end else if (cnt == CW'(TIMEOUT)) begin
                        m_dat_o <= 8'hFF;
                        m_ack_o <= gnt_o;
                        err_q   <= 1'b1;
                        state   <= S_DONE;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                S_DONE: begin
                    ptr   <= next_ptr;
                    gnt_o <= '0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
`else
    assign m_err_o = 1'b0;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state   <= S_IDLE;
            ptr     <= '0;
            gidx    <= '0;
            m_ack_o <= '0;
            m_dat_o <= '0;
            gnt_o   <= '0;
            stb_o   <= 1'b0;
            we_o    <= 1'b0;
            adr_o   <= '0;
            dat_o   <= '0;
        end else begin
            stb_o   <= 1'b0;
            m_ack_o <= '0;
            case (state)
                S_IDLE: begin
                    if (sel_valid) begin
                        we_o  <= sel_we;
                        adr_o <= sel_adr;
                        dat_o <= sel_dat;
                        gnt_o <= sel_onehot;
                        gidx  <= sel_idx;
                        stb_o <= 1'b1;
                        state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    // An ack in the strobe cycle itself belongs to nobody.
                    if (!stb_o && ack_i) begin
                        m_dat_o <= dat_i;
                        m_ack_o <= gnt_o;
                        state   <= S_DONE;
                    end
                end
                S_DONE: begin
                    ptr   <= next_ptr;
                    gnt_o <= '0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
`endif

endmodule
